// File: rtl/wm_pkg.sv
// wm_pkg: shared types and default constants for the washing-machine
// sensor/timer stage and the controller FSM that consumes its outputs.
//   wm_state_e  - phase-timer FSM state encoding (3-bit)
//   WM_*        - default parameter values shared across the controller slice
package wm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WASH      = 3'd1,
    ST_WASH_DONE = 3'd2,
    ST_SPIN      = 3'd3,
    ST_SPIN_DONE = 3'd4
  } wm_state_e;

  localparam int WM_PRESCALE   = 1000;
  localparam int WM_LEVEL_W    = 8;
  localparam int WM_FULL_LEVEL = 200;
  localparam int WM_FILL_STEP  = 4;
  localparam int WM_DRAIN_STEP = 5;
  localparam int WM_CNT_W      = 16;
  localparam int WM_WASH_TICKS = 600;
  localparam int WM_SPIN_TICKS = 300;
  localparam int WM_FILL_TMO   = 100;

endpackage

// File: rtl/wm_sense_timer_if.sv
// wm_sense_timer_if: command/status bundle between the controller FSM
// (master) and the sensor/timer stage (slave).
//   commands : timer_clr, fillvalve_on, drainvalve_on, motor_on, spin_en
//   status   : level, filled, drained, cycletime_out, spintime_out, fault
interface wm_sense_timer_if #(
  parameter int LEVEL_W = 8
) ();
  logic               timer_clr;
  logic               fillvalve_on;
  logic               drainvalve_on;
  logic               motor_on;
  logic               spin_en;
  logic [LEVEL_W-1:0] level;
  logic               filled;
  logic               drained;
  logic               cycletime_out;
  logic               spintime_out;
  logic               fault;

  modport master (
    output timer_clr, fillvalve_on, drainvalve_on, motor_on, spin_en,
    input  level, filled, drained, cycletime_out, spintime_out, fault
  );

  modport slave (
    input  timer_clr, fillvalve_on, drainvalve_on, motor_on, spin_en,
    output level, filled, drained, cycletime_out, spintime_out, fault
  );
endinterface

// File: rtl/wm_tick_gen.sv
// wm_tick_gen: free-running prescaler producing a one-clk time tick.
//   clk  - system clock
//   rst  - synchronous active-high reset (counter to 0)
//   tick - high for the one clk in which the counter wraps back to 0;
//          first tick is the PRESCALE-th cycle after reset release
module wm_tick_gen #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // Decoded from the count so the consumer acts on the wrapping edge itself.
  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/wm_sense_timer.sv
// wm_sense_timer: water-level model, fill-timeout watchdog and wash/spin
// phase timer feeding the washing-machine controller FSM.
//   clk, rst - system clock, synchronous active-high reset
//   bus      - slave side of wm_sense_timer_if:
//              in : timer_clr, fillvalve_on, drainvalve_on, motor_on, spin_en
//              out: level, filled, drained (level decodes, combinational),
//                   cycletime_out, spintime_out, fault (registered)
// timer_clr aborts the phase timers and clears fault; the level model and
// the prescaler keep running through it.
module wm_sense_timer
  import wm_pkg::*;
#(
  parameter int PRESCALE   = WM_PRESCALE,
  parameter int LEVEL_W    = WM_LEVEL_W,
  parameter int FULL_LEVEL = WM_FULL_LEVEL,
  parameter int FILL_STEP  = WM_FILL_STEP,
  parameter int DRAIN_STEP = WM_DRAIN_STEP,
  parameter int CNT_W      = WM_CNT_W,
  parameter int WASH_TICKS = WM_WASH_TICKS,
  parameter int SPIN_TICKS = WM_SPIN_TICKS,
  parameter int FILL_TMO   = WM_FILL_TMO
) (
  input logic             clk,
  input logic             rst,
  wm_sense_timer_if.slave bus
);
  localparam logic [LEVEL_W-1:0] FULL_L  = LEVEL_W'(FULL_LEVEL);
  localparam logic [LEVEL_W:0]   FULL_X  = (LEVEL_W+1)'(FULL_LEVEL);
  localparam logic [LEVEL_W:0]   FSTEP_X = (LEVEL_W+1)'(FILL_STEP);
  localparam logic [LEVEL_W-1:0] DSTEP_L = LEVEL_W'(DRAIN_STEP);
  localparam logic [CNT_W-1:0]   WASH_LAST = CNT_W'(WASH_TICKS - 1);
  localparam logic [CNT_W-1:0]   SPIN_LAST = CNT_W'(SPIN_TICKS - 1);
  localparam logic [CNT_W-1:0]   TMO_MAX   = CNT_W'(FILL_TMO);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(FILL_TMO - 1);

  logic               tick;
  logic [LEVEL_W-1:0] lvl_q;
  logic [LEVEL_W:0]   fill_sum;
  logic               filled_w;
  logic               fill_on, drain_on, conflict, timeout;
  logic [CNT_W-1:0]   fill_cnt;
  logic [CNT_W-1:0]   wash_cnt, spin_cnt;
  wm_state_e          state;
  logic               cyc_q, spin_q, fault_q;

  wm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign fill_on  = bus.fillvalve_on;
  assign drain_on = bus.drainvalve_on;

  // ---------------- level model ----------------
  // One extra bit on the sum so a step past FULL_LEVEL near the top of the
  // range cannot wrap before the clamp.
  assign fill_sum = {1'b0, lvl_q} + FSTEP_X;
  assign filled_w = (lvl_q == FULL_L);

  always_ff @(posedge clk) begin
    if (rst) lvl_q <= '0;
    else if (tick) begin
      if (fill_on && !drain_on)
        lvl_q <= (fill_sum >= FULL_X) ? FULL_L : fill_sum[LEVEL_W-1:0];
      else if (drain_on && !fill_on)
        lvl_q <= (lvl_q >= DSTEP_L) ? (lvl_q - DSTEP_L) : '0;
    end
  end

  // ---------------- fill watchdog + fault ----------------
  assign conflict = tick && fill_on && drain_on;
  assign timeout  = tick && fill_on && !filled_w && (fill_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst || bus.timer_clr)      fill_cnt <= '0;
    else if (!fill_on || filled_w) fill_cnt <= '0;
    else if (tick && fill_cnt != TMO_MAX)
      fill_cnt <= fill_cnt + CNT_W'(1);   // parks at FILL_TMO, fault is sticky
  end

  always_ff @(posedge clk) begin
    if (rst || bus.timer_clr)    fault_q <= 1'b0;
    else if (conflict || timeout) fault_q <= 1'b1;
  end

  // ---------------- phase timer ----------------
  // spin_en wins from IDLE; once a phase is running the other command is
  // ignored until the phase returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst || bus.timer_clr) begin
      state    <= ST_IDLE;
      wash_cnt <= '0;
      spin_cnt <= '0;
      cyc_q    <= 1'b0;
      spin_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wash_cnt <= '0;
          spin_cnt <= '0;
          if (bus.spin_en)       state <= ST_SPIN;
          else if (bus.motor_on) state <= ST_WASH;
        end
        ST_WASH: begin
          if (tick && bus.motor_on) begin
            wash_cnt <= wash_cnt + CNT_W'(1);
            if (wash_cnt == WASH_LAST) begin
              state <= ST_WASH_DONE;
              cyc_q <= 1'b1;
            end
          end
        end
        ST_WASH_DONE: begin
          if (!bus.motor_on) begin
            state    <= ST_IDLE;
            wash_cnt <= '0;
            cyc_q    <= 1'b0;
          end
        end
        ST_SPIN: begin
          if (tick && bus.spin_en) begin
            spin_cnt <= spin_cnt + CNT_W'(1);
            if (spin_cnt == SPIN_LAST) begin
              state  <= ST_SPIN_DONE;
              spin_q <= 1'b1;
            end
          end
        end
        ST_SPIN_DONE: begin
          if (!bus.spin_en) begin
            state    <= ST_IDLE;
            spin_cnt <= '0;
            spin_q   <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cyc_q  <= 1'b0;
          spin_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.level         = lvl_q;
  assign bus.filled        = filled_w;
  assign bus.drained       = (lvl_q == '0);
  assign bus.cycletime_out = cyc_q;
  assign bus.spintime_out  = spin_q;
  assign bus.fault         = fault_q;
endmodule

// File: tb/tb_wm_sense_timer.sv
module tb_wm_sense_timer;
  localparam int P    = 4;
  localparam int FULL = 12;
  localparam int DS   = 5;
  localparam int WT   = 3;
  localparam int ST   = 2;
  localparam int TMO  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fill = 0, drain = 0, motor = 0, spin = 0, clr = 0;

  always #5 clk = ~clk;

  wm_sense_timer_if #(.LEVEL_W(8)) ifa ();
  wm_sense_timer_if #(.LEVEL_W(8)) ifb ();

  assign ifa.timer_clr = clr;     assign ifb.timer_clr = clr;
  assign ifa.fillvalve_on = fill; assign ifb.fillvalve_on = fill;
  assign ifa.drainvalve_on = drain; assign ifb.drainvalve_on = drain;
  assign ifa.motor_on = motor;    assign ifb.motor_on = motor;
  assign ifa.spin_en = spin;      assign ifb.spin_en = spin;

  // A: normal fill step; B: fill step 1 so FULL_LEVEL is out of reach in time
  wm_sense_timer #(.PRESCALE(P), .LEVEL_W(8), .FULL_LEVEL(FULL), .FILL_STEP(4),
    .DRAIN_STEP(DS), .CNT_W(16), .WASH_TICKS(WT), .SPIN_TICKS(ST), .FILL_TMO(TMO))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  wm_sense_timer #(.PRESCALE(P), .LEVEL_W(8), .FULL_LEVEL(FULL), .FILL_STEP(1),
    .DRAIN_STEP(DS), .CNT_W(16), .WASH_TICKS(WT), .SPIN_TICKS(ST), .FILL_TMO(TMO))
    u_b (.clk(clk), .rst(rst), .bus(ifb));

  // Reference model: mode 0=idle 1=wash 2=spin, ticks = ticks counted in
  // the phase; the phase is complete when ticks reaches its target.
  typedef struct {
    int level;
    int fc;
    int mode;
    int ticks;
    bit fault;
  } m_t;

  m_t ma, mb;
  int cyc = 0;
  int errs = 0;
  int checks = 0;

  function automatic m_t m_reset();
    m_t r;
    r.level = 0; r.fc = 0; r.mode = 0; r.ticks = 0; r.fault = 0;
    return r;
  endfunction

  function automatic m_t m_next(m_t s, int fstep, bit tk, bit f, bit d,
                                bit mo, bit sp, bit cl);
    m_t n = s;
    if (tk) begin
      if (f && !d)      n.level = (s.level + fstep > FULL) ? FULL : s.level + fstep;
      else if (d && !f) n.level = (s.level < DS) ? 0 : s.level - DS;
      else if (f && d)  n.fault = 1;
    end
    if (!f || s.level == FULL) n.fc = 0;
    else if (tk) begin
      n.fc = s.fc + 1;
      if (n.fc >= TMO) n.fault = 1;
    end
    case (s.mode)
      0: begin
        if (sp)      begin n.mode = 2; n.ticks = 0; end
        else if (mo) begin n.mode = 1; n.ticks = 0; end
      end
      1: begin
        if (s.ticks == WT) begin
          if (!mo) begin n.mode = 0; n.ticks = 0; end
        end else if (tk && mo) n.ticks = s.ticks + 1;
      end
      default: begin
        if (s.ticks == ST) begin
          if (!sp) begin n.mode = 0; n.ticks = 0; end
        end else if (tk && sp) n.ticks = s.ticks + 1;
      end
    endcase
    if (cl) begin n.mode = 0; n.ticks = 0; n.fc = 0; n.fault = 0; end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("a_level",  32'(ifa.level), ma.level);
    chk("a_filled", 32'(ifa.filled), int'(ma.level == FULL));
    chk("a_drained", 32'(ifa.drained), int'(ma.level == 0));
    chk("a_cyc",    32'(ifa.cycletime_out), int'(ma.mode == 1 && ma.ticks == WT));
    chk("a_spin",   32'(ifa.spintime_out), int'(ma.mode == 2 && ma.ticks == ST));
    chk("a_fault",  32'(ifa.fault), int'(ma.fault));
    chk("b_level",  32'(ifb.level), mb.level);
    chk("b_filled", 32'(ifb.filled), int'(mb.level == FULL));
    chk("b_drained", 32'(ifb.drained), int'(mb.level == 0));
    chk("b_cyc",    32'(ifb.cycletime_out), int'(mb.mode == 1 && mb.ticks == WT));
    chk("b_spin",   32'(ifb.spintime_out), int'(mb.mode == 2 && mb.ticks == ST));
    chk("b_fault",  32'(ifb.fault), int'(mb.fault));
  endtask

  // One clock: advance the model with this cycle's inputs, then compare.
  task automatic step();
    bit tk;
    m_t na, nb;
    tk = ((cyc % P) == P - 1);
    if (rst) begin
      na = m_reset(); nb = m_reset(); cyc = 0;
    end else begin
      na = m_next(ma, 4, tk, fill, drain, motor, spin, clr);
      nb = m_next(mb, 1, tk, fill, drain, motor, spin, clr);
      cyc++;
    end
    @(posedge clk);
    #1;
    ma = na; mb = nb;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int lvl_before;
    int n;
    ma = m_reset(); mb = m_reset();

    // reset, then idle
    rst = 1; steps(3);
    rst = 0; steps(20);
    chk("idle_drained", 32'(ifa.drained), 1);
    chk("idle_level", 32'(ifa.level), 0);

    // re-reset so the prescaler phase is known, then fill
    rst = 1; steps(2);
    rst = 0; fill = 1;
    steps(12);
    chk("fill_lvl12", 32'(ifa.level), 12);
    chk("fill_filled", 32'(ifa.filled), 1);
    steps(7);
    chk("tmo_before", 32'(ifb.fault), 0);
    steps(1);
    chk("tmo_fault", 32'(ifb.fault), 1);
    chk("tmo_lvl", 32'(ifb.level), 5);
    chk("full_hold", 32'(ifa.level), 12);
    chk("a_no_fault", 32'(ifa.fault), 0);

    // drain 12 -> 7 -> 2 -> 0
    fill = 0; drain = 1;
    steps(12);
    chk("drain_lvl0", 32'(ifa.level), 0);
    chk("drain_drained", 32'(ifa.drained), 1);
    drain = 0;
    clr = 1; step(); clr = 0;
    chk("clr_fault", 32'(ifb.fault), 0);

    // wash: one counted tick, pause, resume
    motor = 1; steps(3);
    motor = 0; steps(8);
    motor = 1;
    n = 0;
    while (!ifa.cycletime_out && n < 40) begin step(); n++; end
    chk("wash_rise", 32'(ifa.cycletime_out), 1);
    chk("wash_rise_cyc", 32'(cyc), 52);
    steps(3);
    motor = 0; step();
    chk("wash_drop", 32'(ifa.cycletime_out), 0);
    steps(2);

    // spin priority over motor
    motor = 1; spin = 1;
    n = 0;
    while (!ifa.spintime_out && n < 40) begin step(); n++; end
    chk("spin_rise", 32'(ifa.spintime_out), 1);
    chk("spin_no_cyc", 32'(ifa.cycletime_out), 0);
    spin = 0; motor = 0; steps(2);

    // both valves for one tick
    lvl_before = int'(ifa.level);
    fill = 1; drain = 1; steps(4);
    fill = 0; drain = 0; step();
    chk("conf_fault", 32'(ifa.fault), 1);
    chk("conf_level", 32'(ifa.level), lvl_before);
    clr = 1; step(); clr = 0;
    chk("conf_clr", 32'(ifa.fault), 0);

    // abort mid-wash at count 2, then a fresh full wash
    motor = 1;
    n = 0;
    while (!(ma.mode == 1 && ma.ticks == 2) && n < 40) begin step(); n++; end
    chk("abort_reach", 32'(ma.ticks), 2);
    clr = 1; step(); clr = 0;
    chk("abort_cyc", 32'(ifa.cycletime_out), 0);
    n = 0;
    while (!ifa.cycletime_out && n < 40) begin step(); n++; end
    chk("abort_full", 32'(ifa.cycletime_out), 1);
    chk("abort_len", 32'(n >= 2 * P + 1), 1);
    motor = 0; steps(2);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      clr   = ($urandom_range(0, 59) == 0);
      fill  = ($urandom_range(0, 2) == 0);
      drain = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) motor = ~motor;
      if ($urandom_range(0, 9) == 0) spin = ~spin;
      step();
    end
    rst = 0; clr = 0; fill = 0; drain = 0; motor = 0; spin = 0;
    steps(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
